// File: rtl/uart_boot_loader.sv
// Boot loader: parses a framed image from the UART byte stream, writes it to memory
// and holds the core in reset until it is accepted. Define LOADER_CHECKSUM_EN for a trailing checksum byte.
module uart_boot_loader #(
  parameter int unsigned MEM_SIZE     = 256,
  parameter logic [7:0]  SYNC_BYTE    = 8'hA5,
  parameter int unsigned TIMEOUT_CLKS = 1000000,
  parameter int unsigned CNT_WIDTH    = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [7:0]           rx_data,
  input  logic                 rx_valid,
  output logic [31:0]          mem_addr,
  output logic                 mem_write_en,
  output logic [31:0]          mem_write_val,
  output logic                 core_reset,
  output logic                 load_done,
  output logic                 load_error,
  output logic [CNT_WIDTH-1:0] words_written
);

  localparam int unsigned   TW         = (TIMEOUT_CLKS > 1) ? $clog2(TIMEOUT_CLKS) : 1;
  localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT_CLKS - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_CNT,
    S_DATA,
`ifdef LOADER_CHECKSUM_EN
    S_CSUM,
`endif
    S_DONE,
    S_ERROR
  } state_t;

  // State entered once the last payload word (or a zero count) has been taken.
`ifdef LOADER_CHECKSUM_EN
  localparam state_t TAIL = S_CSUM;
`else
  localparam state_t TAIL = S_DONE;
`endif

  state_t               state, state_nxt;
  logic [1:0]           byte_idx;
  logic [31:0]          base;
  logic [CNT_WIDTH-1:0] count;
  logic [23:0]          word_buf;
  logic [TW-1:0]        timer;
`ifdef LOADER_CHECKSUM_EN
  logic [7:0]           csum;
`endif

  logic                 is_sync, in_frame, timed_out, range_bad, last_word;
  logic [CNT_WIDTH-1:0] count_full, ww_inc;
  logic [32:0]          base_ext;

  assign is_sync    = rx_valid && (rx_data == SYNC_BYTE);
  assign count_full = CNT_WIDTH'({rx_data, count[7:0]});
  // 33-bit compare so a base near 2^32 cannot wrap past the memory-size check.
  assign base_ext   = {1'b0, base};
  assign range_bad  = (base_ext >= 33'(MEM_SIZE)) ||
                      ((base_ext + 33'(count_full)) > 33'(MEM_SIZE));
  assign ww_inc     = words_written + CNT_WIDTH'(1);
  assign last_word  = (ww_inc == count);
  assign timed_out  = (timer == TIMER_LAST);

  assign load_done  = (state == S_DONE);
  assign load_error = (state == S_ERROR);
  assign core_reset = (state != S_DONE);

  always_comb begin
    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    state_nxt = state;
    in_frame  = 1'b0;
    case (state)
      S_IDLE, S_ERROR: if (is_sync) state_nxt = S_ADDR;
      S_ADDR: begin
        in_frame = 1'b1;
        if (rx_valid && byte_idx == 2'd3) state_nxt = S_CNT;
      end
      S_CNT: begin
        in_frame = 1'b1;
        if (rx_valid && byte_idx == 2'd1) begin
          if (count_full == '0)  state_nxt = TAIL;
          else if (range_bad)    state_nxt = S_ERROR;
          else                   state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        in_frame = 1'b1;
        if (rx_valid && byte_idx == 2'd3 && last_word) state_nxt = TAIL;
      end
`ifdef LOADER_CHECKSUM_EN
      S_CSUM: begin
        in_frame = 1'b1;
        if (rx_valid) state_nxt = (rx_data == csum) ? S_DONE : S_ERROR;
      end
`endif
      default: ;
    endcase
    if (in_frame && !rx_valid && timed_out) state_nxt = S_IDLE;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= S_IDLE;
      byte_idx      <= '0;
      base          <= '0;
      count         <= '0;
      word_buf      <= '0;
      timer         <= '0;
      mem_addr      <= '0;
      mem_write_en  <= 1'b0;
      mem_write_val <= '0;
      words_written <= '0;
`ifdef LOADER_CHECKSUM_EN
      csum          <= '0;
`endif
    end else begin
      state        <= state_nxt;
      mem_write_en <= 1'b0;
      if (!in_frame || rx_valid || timed_out) timer <= '0;
      else                                    timer <= timer + TW'(1);

      if (rx_valid) begin
        case (state)
          S_IDLE, S_ERROR: if (is_sync) begin
            byte_idx      <= '0;
            words_written <= '0;
`ifdef LOADER_CHECKSUM_EN
            csum          <= '0;
`endif
          end
          S_ADDR: begin
            base     <= {rx_data, base[31:8]};
            byte_idx <= byte_idx + 2'd1;
          end
          S_CNT: begin
            if (byte_idx == 2'd0) begin
              count    <= CNT_WIDTH'(rx_data);
              byte_idx <= 2'd1;
            end else begin
              count    <= count_full;
              byte_idx <= 2'd0;
            end
          end
          S_DATA: begin
            word_buf <= {rx_data, word_buf[23:8]};
            byte_idx <= byte_idx + 2'd1;
            if (byte_idx == 2'd3) begin
              mem_write_val <= {rx_data, word_buf};
              mem_addr      <= base + 32'(words_written);
              mem_write_en  <= 1'b1;
              words_written <= ww_inc;
            end
          end
          default: ;
        endcase
`ifdef LOADER_CHECKSUM_EN
        if (state == S_ADDR || state == S_CNT || state == S_DATA) csum <= csum + rx_data;
`endif
      end
    end
  end

endmodule
